// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants used by the write-back stage and its HI/LO register file.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;
endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with synchronous reset, joint commit and
// a same-cycle read bypass so mfhi/mflo see a value committed in the same cycle.
module hilo_reg #(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  import mips_pkg::*;

  logic [DATA_W-1:0] hi_d, hi_q;
  logic [DATA_W-1:0] lo_d, lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (we) begin
      hi_d = hi_in;
      lo_d = lo_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Bypass uses the incoming pair so a read alongside a commit returns the new value.
  always_comb begin
    rd_data = (sel == SEL_HI) ? hi_q : lo_q;
    if (we) rd_data = (sel == SEL_HI) ? hi_in : lo_in;
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: register-file write data/strobe, $zero suppression, HI/LO ownership.
// Optional retirement counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] DataMemory,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [REG_AW-1:0] destinationReg,
  input  logic [DATA_W-1:0] Hi,
  input  logic [DATA_W-1:0] Lo,
  input  logic              WriteEnable,
  input  logic              ReadEnable,
  input  logic              HiLoSel,
  output logic              RegWriteEn_out,
  output logic [REG_AW-1:0] WriteReg_out,
  output logic [DATA_W-1:0] WriteData_out,
  output logic [DATA_W-1:0] HI_out,
  output logic [DATA_W-1:0] LO_out,
  output logic [31:0]       RetiredCount_out
);
  import mips_pkg::*;

  logic [DATA_W-1:0] hilo_rd;

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk     (Clock),
    .rst     (Reset),
    .we      (WriteEnable),
    .hi_in   (Hi),
    .lo_in   (Lo),
    .sel     (HiLoSel),
    .rd_data (hilo_rd),
    .hi_out  (HI_out),
    .lo_out  (LO_out)
  );

  always_comb begin
    WriteData_out = ALUResult;
    if (ReadEnable)    WriteData_out = hilo_rd;
    else if (MemtoReg) WriteData_out = DataMemory;
  end

  assign RegWriteEn_out = RegWrite && (destinationReg != REG_ZERO);
  assign WriteReg_out   = destinationReg;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt_d, retired_cnt_q;

  // Writes to $zero still retire an instruction, so RegWrite is counted unmasked.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (RegWrite || WriteEnable) retired_cnt_d = retired_cnt_q + 32'd1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) retired_cnt_q <= '0;
    else       retired_cnt_q <= retired_cnt_d;
  end

  assign RetiredCount_out = retired_cnt_q;
`else
  assign RetiredCount_out = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: random and directed instructions against a behavioural model.
module tb_wb_stage;
  logic        Clock = 1'b0;
  logic        Reset, RegWrite, MemtoReg, WriteEnable, ReadEnable, HiLoSel;
  logic [31:0] DataMemory, ALUResult, Hi, Lo;
  logic [4:0]  destinationReg;
  logic        RegWriteEn_out;
  logic [4:0]  WriteReg_out;
  logic [31:0] WriteData_out, HI_out, LO_out, RetiredCount_out;

  wb_stage dut (
    .Clock(Clock), .Reset(Reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .DataMemory(DataMemory), .ALUResult(ALUResult), .destinationReg(destinationReg),
    .Hi(Hi), .Lo(Lo), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .HiLoSel(HiLoSel),
    .RegWriteEn_out(RegWriteEn_out), .WriteReg_out(WriteReg_out), .WriteData_out(WriteData_out),
    .HI_out(HI_out), .LO_out(LO_out), .RetiredCount_out(RetiredCount_out)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        en;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  logic [31:0] m_hi = 0, m_lo = 0, m_cnt = 0;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest expectation.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "wdata", WriteData_out, e.wd);
      check(e.name, "wreg", {27'd0, WriteReg_out}, {27'd0, e.wr});
      check(e.name, "wen", {31'd0, RegWriteEn_out}, {31'd0, e.en});
      check(e.name, "hi", HI_out, e.hi);
      check(e.name, "lo", LO_out, e.lo);
      check(e.name, "cnt", RetiredCount_out, e.cnt);
    end
  end

  task automatic drive(input string nm, input logic rst, input logic rw, input logic mtr,
                       input logic [31:0] dm, input logic [31:0] alu, input logic [4:0] dst,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic we, input logic re, input logic sel);
    exp_t e;
    Reset = rst; RegWrite = rw; MemtoReg = mtr; DataMemory = dm; ALUResult = alu;
    destinationReg = dst; Hi = hi; Lo = lo; WriteEnable = we; ReadEnable = re; HiLoSel = sel;
    e.name = nm;
    if (re) begin
      if (we) e.wd = sel ? hi : lo;
      else    e.wd = sel ? m_hi : m_lo;
    end else begin
      e.wd = mtr ? dm : alu;
    end
    e.wr = dst;
    e.en = rw && (dst != 0);
    e.hi = m_hi;
    e.lo = m_lo;
`ifdef WB_RETIRE_CNT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
    exp_q.push_back(e);
    @(posedge Clock);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_cnt = 0;
    end else begin
      if (we) begin m_hi = hi; m_lo = lo; end
      if (rw || we) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic idle(input string nm, input logic rst);
    drive(nm, rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1; RegWrite = 0; MemtoReg = 0; DataMemory = 0; ALUResult = 0; destinationReg = 0;
    Hi = 0; Lo = 0; WriteEnable = 0; ReadEnable = 0; HiLoSel = 0;
    @(posedge Clock); @(posedge Clock); #1;

    idle("reset_a", 1);
    idle("reset_b", 1);
    idle("post_reset", 0);

    drive("load",      0, 1, 1, 32'hDEADBEEF, 32'h1234, 5'd8, 0, 0, 0, 0, 0);
    drive("alu",       0, 1, 0, 32'hDEADBEEF, 32'h1234, 5'd8, 0, 0, 0, 0, 0);
    drive("zero_dst",  0, 1, 0, 0, 32'd5, 5'd0, 0, 0, 0, 0, 0);
    drive("commit",    0, 0, 0, 0, 0, 5'd0, 32'hAAAA0000, 32'h0000BBBB, 1, 0, 0);
    drive("mfhi",      0, 1, 0, 0, 32'h55, 5'd2, 0, 0, 0, 1, 1);
    drive("mflo",      0, 1, 1, 32'h66, 32'h55, 5'd2, 0, 0, 0, 1, 0);
    drive("bypass_lo", 0, 1, 0, 0, 0, 5'd3, 32'h11, 32'h77, 1, 1, 0);
    drive("bypass_hi", 0, 1, 0, 0, 0, 5'd3, 32'h99, 32'h88, 1, 1, 1);
    drive("mf_zero",   0, 1, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1);
    idle("after_mf", 0);
    drive("rst_vs_we", 1, 0, 0, 0, 0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);
    idle("after_rst_we", 0);

`ifdef WB_RETIRE_CNT_EN
    force dut.retired_cnt_q = 32'hFFFFFFFF;
    #1 release dut.retired_cnt_q;
    m_cnt = 32'hFFFFFFFF;
    drive("wrap_pre", 0, 1, 0, 0, 32'h1, 5'd4, 0, 0, 0, 0, 0);
    idle("wrap_post", 0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [4:0] dst;
      dst = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      drive("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
            $urandom, $urandom, dst, $urandom, $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline, fed directly by the MEM/WB pipeline register outputs. Selects the register-file write data from the memory load value, the ALU result, or the architectural HI/LO pair, and suppresses writes to $zero. Owns the HI/LO architectural registers, committed by mult/div-class instructions. Drives the register-file write port and the WB-stage forwarding source.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-file address width

Ports:
- Clock  in  1  rising-edge clock for all state
- Reset  in  1  synchronous, active-high; clears all state
- RegWrite  in  1  instruction writes a GPR
- MemtoReg  in  1  1 = write data from DataMemory, 0 = from ALUResult
- DataMemory  in  DATA_W  load value from MEM/WB
- ALUResult  in  DATA_W  ALU result from MEM/WB
- destinationReg  in  REG_AW  GPR destination
- Hi  in  DATA_W  HI value produced by mult/div
- Lo  in  DATA_W  LO value produced by mult/div
- WriteEnable  in  1  commit Hi/Lo into HI/LO registers
- ReadEnable  in  1  mfhi/mflo: GPR write data comes from HI/LO
- HiLoSel  in  1  when ReadEnable: 1 = HI, 0 = LO
- RegWriteEn_out  out  1  register-file write strobe
- WriteReg_out  out  REG_AW  register-file write address
- WriteData_out  out  DATA_W  register-file write data
- HI_out  out  DATA_W  current architectural HI
- LO_out  out  DATA_W  current architectural LO
- RetiredCount_out  out  32  retirement counter (see Configuration)

## Operation
- RegWriteEn_out = RegWrite & (destinationReg != 0); writes to $zero are always dropped.
- WriteReg_out = destinationReg, passed through unchanged.
- WriteData_out priority:
  - ReadEnable: the HI/LO source, selected by HiLoSel.
  - Otherwise MemtoReg: DataMemory.
  - Otherwise: ALUResult.
- HI/LO source when ReadEnable=1:
  - WriteEnable=0: HI_out or LO_out.
  - WriteEnable=1 in the same cycle: bypass Hi or Lo, so the read returns the new value.
- HI/LO registers:
  - On a rising edge with WriteEnable=1 and Reset=0: HI <= Hi, LO <= Lo. Both always update together.
  - Otherwise they hold.
- No handshake. The stage accepts one instruction per cycle and never stalls.

## Timing
- WriteData_out, WriteReg_out and RegWriteEn_out are combinational from the inputs (0-cycle latency). The register file samples them on the rising edge.
- HI_out and LO_out are registered. A commit on edge N is visible after edge N.
- Reset values: HI_out = 0, LO_out = 0, RetiredCount_out = 0. Combinational outputs follow their inputs during reset.
- Reset asserted on the same edge as WriteEnable: Reset wins, and HI/LO become 0.
- Reset deasserts mid-stream: the first edge after deassertion operates normally. No warm-up cycle.
- ReadEnable together with RegWrite=1 and destinationReg=0: write data is still computed, but the write strobe stays low.

## Configuration
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - RetiredCount_out is a 32-bit counter incrementing on each non-reset edge where RegWrite | WriteEnable.
  - Writes to $zero still count.
  - Wraps from 0xFFFFFFFF to 0. Reset clears it.
- Undefined:
  - No counter flops are built.
  - RetiredCount_out is tied to 0; the port stays present so instantiations are unchanged.

## Structure
- Shared package mips_pkg holds DATA_W, REG_AW, the REG_ZERO = 0 constant and the HiLoSel encodings (SEL_LO = 0, SEL_HI = 1).
- One sub-module, hilo_reg:
  - Contents: the HI/LO flop pair with synchronous reset, write enable and the same-cycle read bypass mux.
  - wb_stage instantiates it and adds the write-data mux, $zero suppression and the optional counter.

## Test plan
- Reset for 2 cycles, then idle inputs -> HI_out = LO_out = 0, RetiredCount_out = 0, RegWriteEn_out = 0.
- RegWrite=1, MemtoReg=1, DataMemory=0xDEADBEEF, ALUResult=0x1234, destinationReg=8 -> WriteData_out = 0xDEADBEEF, WriteReg_out = 8, RegWriteEn_out = 1. Same stimulus with MemtoReg=0 -> 0x1234.
- RegWrite=1, destinationReg=0, ALUResult=5 -> RegWriteEn_out = 0. With the macro defined, RetiredCount_out increments by 1.
- WriteEnable=1, Hi=0xAAAA0000, Lo=0x0000BBBB for one cycle; next cycle ReadEnable=1, HiLoSel=1, RegWrite=1, destinationReg=2 -> WriteData_out = 0xAAAA0000. With HiLoSel=0 -> 0x0000BBBB.
- Same-cycle WriteEnable=1 (Lo=0x77), ReadEnable=1, HiLoSel=0 -> WriteData_out = 0x77 in that cycle; LO_out = 0x77 after the edge.
- Reset and WriteEnable asserted on the same edge with Hi=0xFFFFFFFF -> HI_out = 0 after the edge. Separately, force the counter to 0xFFFFFFFF, then one retiring cycle -> RetiredCount_out = 0.
